// File: rtl/reloj_pkg.sv
// Shared definitions for the clock/timer/alarm front panel: cycle conversion,
// repeat FSM states and button indices.
package reloj_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RPT  = 2'd2
  } rpt_state_t;

  localparam int BTN_AUM  = 0;
  localparam int BTN_DISM = 1;
  localparam int BTN_DER  = 2;
  localparam int BTN_IZQ  = 3;
  localparam int BTN_DOCE = 4;
  localparam int N_BTN    = 5;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                               input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/antirrebote.sv
// One button: 2-FF synchroniser, stability-counter debounce and a 0->1 press
// strobe taken from the debounced level.
module antirrebote #(
  parameter int unsigned DEB = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db,
  output logic press
);

  localparam int CW = $clog2(DEB + 1);
  localparam logic [CW-1:0] DEB_C = CW'(DEB);

  logic          sync1;
  logic          sync2;
  logic          db_prev;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      db      <= 1'b0;
      db_prev <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      db_prev <= db;
      // Any return to the current level restarts the stability window.
      if (sync2 == db) begin
        cnt <= '0;
      end else if (cnt == DEB_C) begin
        db  <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = db & ~db_prev;

endmodule

// File: rtl/boton_acondicionador.sv
// Front-panel button conditioner: debounced press pulses, auto-repeat on
// increment/decrement with a both-held lockout, and the 12/24-hour toggle.
module boton_acondicionador
  import reloj_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned HOLD_MS     = 500,
  parameter int unsigned REPEAT_MS   = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_aum,
  input  logic       btn_dism,
  input  logic       btn_der,
  input  logic       btn_izq,
  input  logic       btn_doce_24,
  output logic       aumenta,
  output logic       disminuye,
  output logic       corre_der,
  output logic       corre_izq,
  output logic       doce_24,
  output rpt_state_t estado_aum,
  output rpt_state_t estado_dism
);

  localparam int unsigned DEB     = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int unsigned HOLD    = ms_to_cycles(CLK_HZ, HOLD_MS);
  localparam int unsigned REP     = ms_to_cycles(CLK_HZ, REPEAT_MS);
  localparam int unsigned CNT_MAX = (HOLD > REP) ? HOLD : REP;
  localparam int          CW      = $clog2(CNT_MAX + 1);
  // Down-counters reach zero exactly HOLD / REP cycles after the pulse edge.
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD - 1);
  localparam logic [CW-1:0] REP_LD  = CW'(REP - 1);

  logic [N_BTN-1:0] raw_v;
  logic [N_BTN-1:0] db_v;
  logic [N_BTN-1:0] press_v;

  assign raw_v[BTN_AUM]  = btn_aum;
  assign raw_v[BTN_DISM] = btn_dism;
  assign raw_v[BTN_DER]  = btn_der;
  assign raw_v[BTN_IZQ]  = btn_izq;
  assign raw_v[BTN_DOCE] = btn_doce_24;

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    antirrebote #(
      .DEB (DEB)
    ) u_antirrebote (
      .clk   (clk),
      .reset (reset),
      .raw   (raw_v[g]),
      .db    (db_v[g]),
      .press (press_v[g])
    );
  end

  // Only aum/dism use the level; the rest act on press strobes alone.
  logic unused_db;
  assign unused_db = &{1'b0, db_v[BTN_DER], db_v[BTN_IZQ], db_v[BTN_DOCE]};

  rpt_state_t    st    [2];
  rpt_state_t    st_n  [2];
  logic [CW-1:0] cnt   [2];
  logic [CW-1:0] cnt_n [2];
  logic [1:0]    pulse_n;
  logic [1:0]    rpt_db;
  logic [1:0]    rpt_press;
  logic          conflict;

  assign rpt_db    = {db_v[BTN_DISM], db_v[BTN_AUM]};
  assign rpt_press = {press_v[BTN_DISM], press_v[BTN_AUM]};
  assign conflict  = &rpt_db;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        st[i]  <= IDLE;
        cnt[i] <= '0;
      end
      aumenta   <= 1'b0;
      disminuye <= 1'b0;
      corre_der <= 1'b0;
      corre_izq <= 1'b0;
      doce_24   <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        st[i]  <= st_n[i];
        cnt[i] <= cnt_n[i];
      end
      aumenta   <= pulse_n[0];
      disminuye <= pulse_n[1];
      corre_der <= press_v[BTN_DER];
      corre_izq <= press_v[BTN_IZQ];
      if (press_v[BTN_DOCE]) begin
        doce_24 <= ~doce_24;
      end
    end
  end

  always_comb begin
    pulse_n = '0;
    for (int i = 0; i < 2; i++) begin
      st_n[i]  = st[i];
      cnt_n[i] = cnt[i];
      case (st[i])
        IDLE: begin
          if (rpt_press[i]) begin
            pulse_n[i] = 1'b1;
            cnt_n[i]   = HOLD_LD;
            st_n[i]    = WAIT;
          end
        end
        WAIT, RPT: begin
          if (!rpt_db[i]) begin
            cnt_n[i] = '0;
            st_n[i]  = IDLE;
          end else if (cnt[i] == '0) begin
            pulse_n[i] = 1'b1;
            cnt_n[i]   = REP_LD;
            st_n[i]    = RPT;
          end else begin
            cnt_n[i] = cnt[i] - 1'b1;
          end
        end
        default: begin
          cnt_n[i] = '0;
          st_n[i]  = IDLE;
        end
      endcase
      // Both held: silence both and demand a fresh press edge afterwards.
      if (conflict) begin
        pulse_n[i] = 1'b0;
        cnt_n[i]   = '0;
        st_n[i]    = IDLE;
      end
    end
  end

  assign estado_aum  = st[0];
  assign estado_dism = st[1];

endmodule

// File: tb/tb_boton_acondicionador.sv
// Directed bench for boton_acondicionador at CLK_HZ=1000 (DEB=20, HOLD=500,
// REP=100); output events are queued as {id, cycle} and checked by a monitor.
module tb_boton_acondicionador;
  import reloj_pkg::*;

  localparam int EW = 35;

  localparam logic [2:0] ID_AUM  = 3'd0;
  localparam logic [2:0] ID_DISM = 3'd1;
  localparam logic [2:0] ID_DER  = 3'd2;
  localparam logic [2:0] ID_IZQ  = 3'd3;
  localparam logic [2:0] ID_DOCE = 3'd4;

  // Clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_aum = 1'b0;
  logic btn_dism = 1'b0;
  logic btn_der = 1'b0;
  logic btn_izq = 1'b0;
  logic btn_doce_24 = 1'b0;
  logic aumenta;
  logic disminuye;
  logic corre_der;
  logic corre_izq;
  logic doce_24;
  rpt_state_t estado_aum;
  rpt_state_t estado_dism;

  always #5 clk = ~clk;

  // cyc is the index of the most recent rising edge
  int cyc = -1;
  always @(posedge clk) cyc <= cyc + 1;

  boton_acondicionador #(
    .CLK_HZ      (1000),
    .DEBOUNCE_MS (20),
    .HOLD_MS     (500),
    .REPEAT_MS   (100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_aum     (btn_aum),
    .btn_dism    (btn_dism),
    .btn_der     (btn_der),
    .btn_izq     (btn_izq),
    .btn_doce_24 (btn_doce_24),
    .aumenta     (aumenta),
    .disminuye   (disminuye),
    .corre_der   (corre_der),
    .corre_izq   (corre_izq),
    .doce_24     (doce_24),
    .estado_aum  (estado_aum),
    .estado_dism (estado_dism)
  );

  // Scoreboard
  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [EW-1:0] ev(input logic [2:0] id, input int c);
    return {id, 32'(c)};
  endfunction

  // Monitor: every pulse, and every doce_24 change, is one event
  logic          doce_prev = 1'b0;
  logic [4:0]    mon_hit;
  logic [EW-1:0] mon_act;
  logic [EW-1:0] mon_exp;

  always @(negedge clk) begin
    mon_hit = {doce_24 != doce_prev, corre_izq, corre_der, disminuye, aumenta};
    doce_prev = doce_24;
    for (int i = 0; i < 5; i++) begin
      if (mon_hit[i]) begin
        mon_act = ev(3'(i), cyc);
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event: got id %0d at cycle %0d, required no event", i, cyc);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_exp !== mon_act) begin
            n_bad++;
            $display("FAIL event: got id %0d at cycle %0d, required id %0d at cycle %0d",
                     i, cyc, mon_exp[34:32], mon_exp[31:0]);
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic at_edge(input int k);
    while (cyc < k - 1) @(negedge clk);
  endtask

  task automatic expect_ev(input logic [2:0] id, input int c);
    exp_q.push_back(ev(id, c));
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_bit({tag, "_aumenta"},   aumenta,   1'b0);
    check_bit({tag, "_disminuye"}, disminuye, 1'b0);
    check_bit({tag, "_corre_der"}, corre_der, 1'b0);
    check_bit({tag, "_corre_izq"}, corre_izq, 1'b0);
    check_bit({tag, "_doce_24"},   doce_24,   1'b0);
  endtask

  int b;

  initial begin
    // Reset held for edges 0..3
    reset = 1'b0;
    at_edge(4);
    reset = 1'b1;
    at_edge(6);
    check_all_zero("reset");

    // Clean press: sampled at edge 10, single pulse at 33, nothing while held
    b = 10;
    expect_ev(ID_DER, b + 23);
    at_edge(b);
    btn_der = 1'b1;
    at_edge(b + 1000);
    btn_der = 1'b0;

    // Bounce: 5-cycle toggles for 60 cycles, then settles high
    b = 1100;
    expect_ev(ID_IZQ, b + 60 + 23);
    for (int i = 0; i <= 12; i++) begin
      at_edge(b + 5 * i);
      btn_izq = ~btn_izq;
    end
    at_edge(b + 200);
    btn_izq = 1'b0;

    // Auto-repeat: held 900 cycles
    b = 1400;
    expect_ev(ID_AUM, b + 23);
    expect_ev(ID_AUM, b + 523);
    expect_ev(ID_AUM, b + 623);
    expect_ev(ID_AUM, b + 723);
    expect_ev(ID_AUM, b + 823);
    at_edge(b);
    btn_aum = 1'b1;
    at_edge(b + 900);
    btn_aum = 1'b0;

    // Conflict: dism joins at +100, released first; aum never resumes
    b = 2400;
    expect_ev(ID_AUM, b + 23);
    at_edge(b);
    btn_aum = 1'b1;
    at_edge(b + 100);
    btn_dism = 1'b1;
    at_edge(b + 600);
    btn_dism = 1'b0;
    at_edge(b + 800);
    btn_aum = 1'b0;

    // Toggle: three separated presses
    b = 3300;
    expect_ev(ID_DOCE, b + 23);
    expect_ev(ID_DOCE, b + 223);
    expect_ev(ID_DOCE, b + 423);
    for (int i = 0; i < 3; i++) begin
      at_edge(b + 200 * i);
      btn_doce_24 = 1'b1;
      at_edge(b + 200 * i + 100);
      btn_doce_24 = 1'b0;
    end

    // Reset mid-repeat: dism held, reset low at edge b+600, fresh press at b+624
    b = 4000;
    expect_ev(ID_DISM, b + 23);
    expect_ev(ID_DISM, b + 523);
    expect_ev(ID_DOCE, b + 600);
    expect_ev(ID_DISM, b + 624);
    at_edge(b);
    btn_dism = 1'b1;
    at_edge(b + 600);
    reset = 1'b0;
    at_edge(b + 601);
    reset = 1'b1;
    at_edge(b + 602);
    check_all_zero("after_reset");
    at_edge(b + 700);
    btn_dism = 1'b0;
    at_edge(b + 800);

    // Final report
    while (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_event: got nothing, required id %0d at cycle %0d",
               mon_exp[34:32], mon_exp[31:0]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
